// File: rtl/ff_chk_pkg.sv
// Shared state encoding and default counter width for the flip-flop stream checker.
package ff_chk_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter; with SAT set it holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && !(SAT && (&count_q))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ff_stream_checker.sv
// Streaming checker for a D flip-flop: each CHECK edge compares Q/Qb against the D
// captured one edge earlier and keeps error statistics for the run.
module ff_stream_checker
   import ff_chk_pkg::*;
#(
   parameter int N_CHECKS = 1000,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic             D,
   input  logic             Q,
   input  logic             Qb,
   output logic             Busy,
   output logic             Done,
   output logic             Pass,
   output logic             Err,
   output logic [CNT_W-1:0] Err_count,
   output logic [CNT_W-1:0] Check_count,
   output logic [CNT_W-1:0] First_fail,
   output state_e           Dbg_state
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CHECKS - 1);
   localparam logic [CNT_W-1:0] NO_FAIL  = '1;

   state_e           state_q, state_d;
   logic             exp_q, exp_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] ff_q, ff_d;
   logic             run_clr;
   logic             cmp_en;
   logic             fail;

   // Case-equality so an X or Z on either DUT output counts as a miscompare.
   assign fail = (Q !== exp_q) || (Qb !== ~exp_q);

   // Start is a level sampled only in IDLE/DONE; Done stays high until the next accepted Start.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      ff_d    = ff_q;
      run_clr = 1'b0;
      cmp_en  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               run_clr = 1'b1;
               ff_d    = NO_FAIL;
               state_d = ST_PRIME;
            end
         end
         ST_PRIME: begin
            exp_d   = D;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            cmp_en = 1'b1;
            exp_d  = D;
            err_d  = fail;
            if (fail && (ff_q == NO_FAIL)) begin
               ff_d = Check_count;
            end
            if (Check_count == LAST_IDX) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         exp_q   <= 1'b0;
         err_q   <= 1'b0;
         ff_q    <= NO_FAIL;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W), .SAT(1'b1)) u_err_cnt (
      .clk_i   (Clk),
      .rst_ni  (Rst_n),
      .clr_i   (run_clr),
      .inc_i   (cmp_en & fail),
      .count_o (Err_count)
   );

   // Legal N_CHECKS keeps this below all-ones, so it never needs to saturate.
   sat_counter #(.CNT_W(CNT_W), .SAT(1'b0)) u_chk_cnt (
      .clk_i   (Clk),
      .rst_ni  (Rst_n),
      .clr_i   (run_clr),
      .inc_i   (cmp_en),
      .count_o (Check_count)
   );

   assign Busy       = (state_q == ST_PRIME) || (state_q == ST_CHECK);
   assign Done       = (state_q == ST_DONE);
   assign Pass       = (state_q == ST_DONE) && (Err_count == '0);
   assign Err        = err_q;
   assign First_fail = ff_q;
   assign Dbg_state  = state_q;

endmodule
